// File: rtl/rx_core_pkg.sv
// Shared definitions for the RX lane gearbox slice.
//   - default sample, lane-count and phase widths
//   - phase_t: phase word at the default phase width
//   - lane_count_legal(): lane counts must be a power of two in 2..16
package rx_core_pkg;

    localparam int unsigned DEFAULT_SAMPLE_WIDTH   = 16;
    localparam int unsigned DEFAULT_NUMBER_OF_LINE = 4;
    localparam int unsigned DEFAULT_PHASE_WIDTH    = 16;

    typedef logic [DEFAULT_PHASE_WIDTH-1:0] phase_t;

    function automatic bit lane_count_legal(input int unsigned n);
        return (n >= 2) && (n <= 16) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rx_lane_phase_gen.sv
// DDS phase accumulator with per-lane offset generation.
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset, clears the accumulator
//   align      : clears the accumulator
//   advance    : a word completed (loaded or dropped); step by N*phase_inc
//   phase_inc  : per-sample phase increment
//   lane_phase : lane k = acc + k*phase_inc (mod 2^PHASE_WIDTH)
module rx_lane_phase_gen
    import rx_core_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH    = DEFAULT_PHASE_WIDTH,
    parameter int unsigned NUMBER_OF_LINE = DEFAULT_NUMBER_OF_LINE
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  align,
    input  logic                                  advance,
    input  logic [PHASE_WIDTH-1:0]                phase_inc,
    output logic [NUMBER_OF_LINE*PHASE_WIDTH-1:0] lane_phase
);

    localparam int unsigned LOG2_LINES = $clog2(NUMBER_OF_LINE);

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] offset;

    // Lane count is a power of two, so N*phase_inc is a plain shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (align) begin
            acc <= '0;
        end else if (advance) begin
            acc <= acc + (phase_inc << LOG2_LINES);
        end
    end

    // Offsets built by repeated addition: lane k gets k*phase_inc.
    always_comb begin
        lane_phase = '0;
        offset     = '0;
        for (int unsigned k = 0; k < NUMBER_OF_LINE; k++) begin
            lane_phase[k*PHASE_WIDTH +: PHASE_WIDTH] = acc + offset;
            offset = offset + phase_inc;
        end
    end

endmodule

// File: rtl/rx_lane_gearbox.sv
// Packs serial ADC samples into NUMBER_OF_LINE-lane words with per-lane DDS phase.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   s_data/s_valid  : serial sample input, no backpressure
//   phase_inc       : per-sample DDS phase increment
//   align           : restarts lane packing and the phase accumulator
//   m_data/m_phase  : packed word and per-lane phase, lane k in slice k
//   m_valid/m_ready : output handshake
//   overflow        : sticky, a completed word was dropped; overflow_clear clears it
module rx_lane_gearbox
    import rx_core_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH   = DEFAULT_SAMPLE_WIDTH,
    parameter int unsigned NUMBER_OF_LINE = DEFAULT_NUMBER_OF_LINE,
    parameter int unsigned PHASE_WIDTH    = DEFAULT_PHASE_WIDTH
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [SAMPLE_WIDTH-1:0]                s_data,
    input  logic                                   s_valid,
    input  logic [PHASE_WIDTH-1:0]                 phase_inc,
    input  logic                                   align,
    output logic [NUMBER_OF_LINE*SAMPLE_WIDTH-1:0] m_data,
    output logic [NUMBER_OF_LINE*PHASE_WIDTH-1:0]  m_phase,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   overflow,
    input  logic                                   overflow_clear
);

    generate
        if (!lane_count_legal(NUMBER_OF_LINE)) begin : g_bad_lane_count
            $error("rx_lane_gearbox: NUMBER_OF_LINE must be a power of two in 2..16");
        end
    endgenerate

    localparam int unsigned SLOT_WIDTH = $clog2(NUMBER_OF_LINE);
    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(NUMBER_OF_LINE - 1);

    logic [SLOT_WIDTH-1:0]                  slot;
    logic [NUMBER_OF_LINE*SAMPLE_WIDTH-1:0] staging;
    logic [NUMBER_OF_LINE*SAMPLE_WIDTH-1:0] completed_word;
    logic [NUMBER_OF_LINE*PHASE_WIDTH-1:0]  lane_phase;
    logic                                   word_done;
    logic                                   out_free;

    // align forces the sample into lane 0, so a word can never finish on it.
    assign word_done = s_valid && !align && (slot == LAST_SLOT);
    assign out_free  = !m_valid || m_ready;

    // The final sample bypasses staging so the word loads with latency 1.
    always_comb begin
        completed_word = staging;
        completed_word[(NUMBER_OF_LINE-1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot    <= '0;
            staging <= '0;
        end else if (align) begin
            staging <= '0;
            if (s_valid) begin
                staging[SAMPLE_WIDTH-1:0] <= s_data;
                slot                      <= SLOT_WIDTH'(1);
            end else begin
                slot <= '0;
            end
        end else if (s_valid) begin
            staging[slot*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_data;
            // Power-of-two lane count: the counter wraps to 0 by itself.
            slot <= slot + SLOT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_data  <= '0;
            m_phase <= '0;
            m_valid <= 1'b0;
        end else if (word_done && out_free) begin
            m_data  <= completed_word;
            m_phase <= lane_phase;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // A drop wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (word_done && !out_free) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

    rx_lane_phase_gen #(
        .PHASE_WIDTH   (PHASE_WIDTH),
        .NUMBER_OF_LINE(NUMBER_OF_LINE)
    ) u_phase_gen (
        .clock     (clock),
        .reset     (reset),
        .align     (align),
        .advance   (word_done),
        .phase_inc (phase_inc),
        .lane_phase(lane_phase)
    );

endmodule

// File: tb/tb_rx_lane_gearbox.sv
module tb_rx_lane_gearbox;
    import rx_core_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    phase_t      phase_inc;
    logic        align;
    logic [63:0] m_data;
    logic [63:0] m_phase;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic        overflow_clear;

    int checks = 0;
    int errors = 0;

    rx_lane_gearbox #(
        .SAMPLE_WIDTH  (16),
        .NUMBER_OF_LINE(4),
        .PHASE_WIDTH   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .phase_inc     (phase_inc),
        .align         (align),
        .m_data        (m_data),
        .m_phase       (m_phase),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .overflow      (overflow),
        .overflow_clear(overflow_clear)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [15:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    logic [63:0] exp_phase [3];

    initial begin
        reset = 1'b1; s_data = '0; s_valid = 1'b0; phase_inc = 16'h1000;
        align = 1'b0; m_ready = 1'b1; overflow_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("reset_m_valid", {63'd0, m_valid}, 64'd0);
        check("reset_m_data", m_data, 64'd0);
        check("reset_m_phase", m_phase, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);

        // Samples 1..12, phase_inc 0x1000, always ready
        exp_phase[0] = 64'h3000_2000_1000_0000;
        exp_phase[1] = 64'h7000_6000_5000_4000;
        exp_phase[2] = 64'hB000_A000_9000_8000;
        for (int i = 1; i <= 12; i++) begin
            sample(16'(i));
            if (i % 4 == 0) begin
                check("pack_valid", {63'd0, m_valid}, 64'd1);
                check("pack_data", m_data, {16'(i), 16'(i - 1), 16'(i - 2), 16'(i - 3)});
                check("pack_phase", m_phase, exp_phase[i / 4 - 1]);
            end else if (i % 4 == 1 && i > 1) begin
                check("valid_drops", {63'd0, m_valid}, 64'd0);
            end else if (i < 4) begin
                check("partial_no_valid", {63'd0, m_valid}, 64'd0);
            end
        end

        // Accumulator wrap with phase_inc 0x7000
        align = 1'b1; tick(); align = 1'b0;
        check("align_keeps_valid", {63'd0, m_valid}, 64'd0);
        phase_inc = 16'h7000;
        for (int i = 0; i < 4; i++) sample(16'h0100 + 16'(i));
        check("wrap_w1_phase", m_phase, 64'h5000_E000_7000_0000);
        for (int i = 0; i < 4; i++) sample(16'h0200 + 16'(i));
        check("wrap_w2_phase", m_phase, 64'h1000_A000_3000_C000);
        check("wrap_w2_data", m_data, 64'h0203_0202_0201_0200);

        // Stall: 9 samples with m_ready low
        align = 1'b1; tick(); align = 1'b0;
        phase_inc = 16'h1000;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) sample(16'h0010 + 16'(i));
        check("stall_w1_valid", {63'd0, m_valid}, 64'd1);
        check("stall_w1_data", m_data, 64'h0013_0012_0011_0010);
        check("stall_no_ovf", {63'd0, overflow}, 64'd0);
        for (int i = 4; i < 8; i++) sample(16'h0010 + 16'(i));
        check("stall_hold_data", m_data, 64'h0013_0012_0011_0010);
        check("stall_hold_phase", m_phase, 64'h3000_2000_1000_0000);
        check("stall_overflow", {63'd0, overflow}, 64'd1);
        sample(16'h0018);
        m_ready = 1'b1;
        tick();
        check("drain_valid", {63'd0, m_valid}, 64'd0);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
        check("ovf_cleared", {63'd0, overflow}, 64'd0);
        for (int i = 1; i < 4; i++) sample(16'h0018 + 16'(i));
        check("w3_data", m_data, 64'h001B_001A_0019_0018);
        check("w3_phase", m_phase, 64'hB000_A000_9000_8000);

        // Drop coinciding with overflow_clear leaves overflow set
        m_ready = 1'b0;
        align = 1'b1; tick(); align = 1'b0;
        check("align_keeps_word", m_data, 64'h001B_001A_0019_0018);
        for (int i = 0; i < 3; i++) sample(16'h0060 + 16'(i));
        overflow_clear = 1'b1;
        sample(16'h0063);
        overflow_clear = 1'b0;
        check("drop_beats_clear", {63'd0, overflow}, 64'd1);
        check("drop_holds_data", m_data, 64'h001B_001A_0019_0018);
        m_ready = 1'b1;
        overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;

        // align with s_valid after two samples
        sample(16'h0021);
        sample(16'h0022);
        align = 1'b1;
        sample(16'h0030);
        align = 1'b0;
        check("align_no_word", {63'd0, m_valid}, 64'd0);
        for (int i = 1; i < 4; i++) sample(16'h0030 + 16'(i));
        check("align_data", m_data, 64'h0033_0032_0031_0030);
        check("align_phase", m_phase, 64'h3000_2000_1000_0000);
        check("align_valid", {63'd0, m_valid}, 64'd1);

        // Reset mid-word with a word held
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) sample(16'h0040 + 16'(i));
        for (int i = 4; i < 7; i++) sample(16'h0040 + 16'(i));
        check("pre_reset_valid", {63'd0, m_valid}, 64'd1);
        reset = 1'b1; m_ready = 1'b1; align = 1'b1;
        sample(16'h0099);
        reset = 1'b0; align = 1'b0;
        check("rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_data", m_data, 64'd0);
        check("rst_phase", m_phase, 64'd0);
        for (int i = 0; i < 4; i++) sample(16'h0050 + 16'(i));
        check("post_rst_data", m_data, 64'h0053_0052_0051_0050);
        check("post_rst_phase", m_phase, 64'h3000_2000_1000_0000);
        check("post_rst_valid", {63'd0, m_valid}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
